// File: rtl/mc_control_pkg.sv
// ============================================================================
// mc_control_pkg -- state type, control-word struct and opcode legality check.
// Optional feature macro: MC_CONTROL_IMM_EN (ADDI support).  Rev 1.0
// ============================================================================
`default_nettype none
package mc_control_pkg;

`include "mc_defs.vh"

`ifdef MC_CONTROL_IMM_EN
    localparam bit IMM_EN = 1'b1;
`else
    localparam bit IMM_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE      = ST_IDLE,
        S_FETCH     = ST_FETCH,
        S_DECODE    = ST_DECODE,
        S_MEM_ADDR  = ST_MEM_ADDR,
        S_MEM_READ  = ST_MEM_READ,
        S_MEM_WB    = ST_MEM_WB,
        S_MEM_WRITE = ST_MEM_WRITE,
        S_R_EXEC    = ST_R_EXEC,
        S_R_WB      = ST_R_WB,
        S_BRANCH    = ST_BRANCH,
        S_JUMP      = ST_JUMP,
        S_IMM_EXEC  = ST_IMM_EXEC,
        S_IMM_WB    = ST_IMM_WB
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (IMM_EN && (op == OP_ADDI));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_defs.vh
// ============================================================================
// mc_defs.vh -- state encodings and opcode constants shared by the control FSM
// and the multicycle datapath.  Rev 1.0
// ============================================================================
`default_nettype none
`ifndef MC_DEFS_VH
`define MC_DEFS_VH

localparam logic [3:0] ST_IDLE      = 4'd0;
localparam logic [3:0] ST_FETCH     = 4'd1;
localparam logic [3:0] ST_DECODE    = 4'd2;
localparam logic [3:0] ST_MEM_ADDR  = 4'd3;
localparam logic [3:0] ST_MEM_READ  = 4'd4;
localparam logic [3:0] ST_MEM_WB    = 4'd5;
localparam logic [3:0] ST_MEM_WRITE = 4'd6;
localparam logic [3:0] ST_R_EXEC    = 4'd7;
localparam logic [3:0] ST_R_WB      = 4'd8;
localparam logic [3:0] ST_BRANCH    = 4'd9;
localparam logic [3:0] ST_JUMP      = 4'd10;
localparam logic [3:0] ST_IMM_EXEC  = 4'd11;
localparam logic [3:0] ST_IMM_WB    = 4'd12;

localparam logic [5:0] OP_RTYPE = 6'h00;
localparam logic [5:0] OP_LW    = 6'h23;
localparam logic [5:0] OP_SW    = 6'h2B;
localparam logic [5:0] OP_BEQ   = 6'h04;
localparam logic [5:0] OP_J     = 6'h02;
localparam logic [5:0] OP_ADDI  = 6'h08;

`endif
`default_nettype wire

// File: rtl/mc_out_decode.sv
// ============================================================================
// mc_out_decode -- state-to-control-word decode for the multicycle controller.
// IMM states decode only when MC_CONTROL_IMM_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none
module mc_out_decode
    import mc_control_pkg::*;
(
    input  state_e     state_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = 2'b01;
                // Only Mealy-style term: the IR/PC update waits for memory.
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = 2'b11;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = 2'b10;
            end
            S_R_WB: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = 2'b01;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_src        = 2'b01;
            end
            S_JUMP: begin
                ctrl_o.pc_write = 1'b1;
                ctrl_o.pc_src   = 2'b10;
            end
`ifdef MC_CONTROL_IMM_EN
            S_IMM_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = 2'b10;
            end
            S_IMM_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
`endif
            default: ctrl_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
// ============================================================================
// mc_control -- multicycle CPU control FSM: state register, next-state logic,
// opcode latch and sticky illegal-opcode flag.
// Optional feature macro: MC_CONTROL_IMM_EN (ADDI states 11/12).  Rev 1.0
// ============================================================================
`default_nettype none
module mc_control
    import mc_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [3:0] state,
    output logic       illegal_op
);

    state_e     state_q, state_d;
    logic [5:0] opcode_q;
    logic       illegal_q;
    ctrl_t      w_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            opcode_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                opcode_q <= opcode;
                if (!op_is_legal(opcode)) begin
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                // Decode uses the live opcode; later states use opcode_q.
                case (opcode)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_CONTROL_IMM_EN
                    OP_ADDI:      state_d = S_IMM_EXEC;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
`ifdef MC_CONTROL_IMM_EN
            S_IMM_EXEC:  state_d = S_IMM_WB;
            S_IMM_WB:    state_d = S_FETCH;
`endif
            default:     state_d = S_FETCH;
        endcase
    end

    mc_out_decode u_out_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (w_ctrl)
    );

    assign pc_write      = w_ctrl.pc_write;
    assign pc_write_cond = w_ctrl.pc_write_cond;
    assign i_or_d        = w_ctrl.i_or_d;
    assign mem_read      = w_ctrl.mem_read;
    assign mem_write     = w_ctrl.mem_write;
    assign ir_write      = w_ctrl.ir_write;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign reg_dst       = w_ctrl.reg_dst;
    assign reg_write     = w_ctrl.reg_write;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign alu_op        = w_ctrl.alu_op;
    assign pc_src        = w_ctrl.pc_src;
    assign state         = state_q;
    assign illegal_op    = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
// ============================================================================
// tb_mc_control -- table-driven, scoreboarded bench for mc_control.
// Expectations for opcode 0x08 follow MC_CONTROL_IMM_EN.  Rev 1.0
// ============================================================================
`default_nettype none
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_ready = 1'b0;
    logic [5:0] opcode = 6'h00;

    logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    mc_control dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_src        (pc_src),
        .state         (state),
        .illegal_op    (illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [5:0]       op;
        int               n;
        logic [0:5][3:0]  path;
    } vec_t;

    exp_t  sb_q[$];
    vec_t  vt[8];
    int    checks = 0;
    int    errors = 0;
    logic  exp_ill = 1'b0;

    wire [15:0] act_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                            ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                            alu_src_b, alu_op, pc_src};

    // Reference control word per state, written from the state table.
    function automatic logic [15:0] ctrl_exp(input logic [3:0] s, input logic mr);
        logic pw, pwc, iod, mrd, mw, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, iod, mrd, mw, irw, m2r, rdst, rw, asa} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (s)
            4'd1:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pw = mr; end
            4'd2:  asb = 2'b11;
            4'd3:  begin asa = 1'b1; asb = 2'b10; end
            4'd4:  begin mrd = 1'b1; iod = 1'b1; end
            4'd5:  begin m2r = 1'b1; rw = 1'b1; end
            4'd6:  begin mw = 1'b1; iod = 1'b1; end
            4'd7:  begin asa = 1'b1; aop = 2'b10; end
            4'd8:  begin rdst = 1'b1; rw = 1'b1; end
            4'd9:  begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; end
            4'd10: begin pw = 1'b1; psrc = 2'b10; end
`ifdef MC_CONTROL_IMM_EN
            4'd11: begin asa = 1'b1; asb = 2'b10; end
            4'd12: rw = 1'b1;
`endif
            default: ;
        endcase
        return {pw, pwc, iod, mrd, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc};
    endfunction

    function automatic logic op_legal(input logic [5:0] op);
`ifdef MC_CONTROL_IMM_EN
        if (op == 6'h08) return 1'b1;
`endif
        return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) ||
               (op == 6'h04) || (op == 6'h02);
    endfunction

    task automatic push_exp(input logic [3:0] es, input logic mr);
        exp_t e;
        e.st   = es;
        e.ctrl = ctrl_exp(es, mr);
        e.ill  = exp_ill;
        sb_q.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        e = sb_q.pop_front();
        checks++;
        if (state !== e.st) begin
            errors++;
            $display("FAIL %s state: got %0d expected %0d at %0t", tag, state, e.st, $time);
        end
        checks++;
        if (act_ctrl !== e.ctrl) begin
            errors++;
            $display("FAIL %s ctrl: got %b expected %b at %0t", tag, act_ctrl, e.ctrl, $time);
        end
        checks++;
        if (illegal_op !== e.ill) begin
            errors++;
            $display("FAIL %s illegal_op: got %b expected %b at %0t", tag, illegal_op, e.ill, $time);
        end
    endtask

    // One clock cycle: drive mem_ready, check this cycle's state/outputs, advance.
    task automatic cyc(input string tag, input logic mr, input int es);
        mem_ready = mr;
        push_exp(4'(es), mr);
        #2;
        compare(tag);
        @(posedge clk);
        #1;
        if (es == 2 && !op_legal(opcode)) exp_ill = 1'b1;
    endtask

    initial begin
        vt[0] = '{op: 6'h23, n: 5, path: {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0}};
        vt[1] = '{op: 6'h2B, n: 4, path: {4'd1, 4'd2, 4'd3, 4'd6, 4'd0, 4'd0}};
        vt[2] = '{op: 6'h00, n: 4, path: {4'd1, 4'd2, 4'd7, 4'd8, 4'd0, 4'd0}};
        vt[3] = '{op: 6'h04, n: 3, path: {4'd1, 4'd2, 4'd9, 4'd0, 4'd0, 4'd0}};
        vt[4] = '{op: 6'h02, n: 3, path: {4'd1, 4'd2, 4'd10, 4'd0, 4'd0, 4'd0}};
`ifdef MC_CONTROL_IMM_EN
        vt[5] = '{op: 6'h08, n: 4, path: {4'd1, 4'd2, 4'd11, 4'd12, 4'd0, 4'd0}};
`else
        vt[5] = '{op: 6'h08, n: 2, path: {4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0}};
`endif
        vt[6] = '{op: 6'h3F, n: 2, path: {4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0}};
        vt[7] = '{op: 6'h23, n: 5, path: {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0}};

        // Reset state
        rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'h00;
        repeat (2) @(posedge clk);
        #1;
        push_exp(4'd0, 1'b1);
        compare("reset");

        rst_n = 1'b1;
        cyc("idle", 1'b1, 0);

        for (int i = 0; i < 8; i++) begin
            opcode = vt[i].op;
            for (int k = 0; k < vt[i].n; k++) begin
                cyc($sformatf("vec%0d_c%0d", i, k), 1'b1, int'(vt[i].path[k]));
            end
        end

        // FETCH waits two cycles for memory
        opcode = 6'h00;
        cyc("fstall0", 1'b0, 1);
        cyc("fstall1", 1'b0, 1);
        cyc("fstall2", 1'b1, 1);
        cyc("fstall_dec", 1'b1, 2);
        cyc("fstall_rex", 1'b1, 7);
        cyc("fstall_rwb", 1'b1, 8);

        // SW with three wait cycles in MEM_WRITE
        opcode = 6'h2B;
        cyc("swst_f", 1'b1, 1);
        cyc("swst_d", 1'b1, 2);
        cyc("swst_a", 1'b1, 3);
        cyc("swst_w0", 1'b0, 6);
        cyc("swst_w1", 1'b0, 6);
        cyc("swst_w2", 1'b0, 6);
        cyc("swst_w3", 1'b1, 6);

        // LW abandoned by reset while waiting in MEM_READ
        opcode = 6'h23;
        cyc("lwab_f", 1'b1, 1);
        cyc("lwab_d", 1'b1, 2);
        cyc("lwab_a", 1'b1, 3);
        mem_ready = 1'b0;
        push_exp(4'd4, 1'b0);
        #2;
        compare("lwab_r");
        rst_n = 1'b0;
        #1;
        exp_ill = 1'b0;
        push_exp(4'd0, 1'b0);
        compare("async_rst");
        @(posedge clk);
        #1;
        push_exp(4'd0, 1'b0);
        compare("rst_hold");
        rst_n = 1'b1;

        opcode = 6'h02;
        cyc("post_idle", 1'b1, 0);
        cyc("post_f", 1'b1, 1);
        cyc("post_d", 1'b1, 2);
        cyc("post_j", 1'b1, 10);
        cyc("post_f2", 1'b1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
